imem_loader: RTL

- Sequences program loading into the instruction fetch stage's instruction memory.
- Accepts a byte stream from the debug/UART receiver over a valid/ready handshake.
- Assembles bytes into 32-bit words and drives the memory write port (write enable, address, data), one word per write pulse.
- Stops on a HALT word or when memory is full, and reports completion so the debug unit can release the CPU.

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Assembles a big-endian byte stream into 32-bit words and writes them to instruction memory until HALT_WORD or full.
// Write strobe one cycle after the 4th byte; no bytes are taken outside RECV. Optional inter-byte timeout: IMEM_LOADER_TIMEOUT_EN.
module imem_loader #(
  parameter int unsigned     SIZE            = 32,
  parameter int unsigned     MAX_INSTRUCTION = 64,
  parameter int unsigned     ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter logic [SIZE-1:0] HALT_WORD       = 32'hFC000000,
  parameter int unsigned     TIMEOUT_CYCLES  = 1024
) (
  input  logic                  i_clk_write,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_truncated,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            byte_cnt;
  logic [SIZE-1:0]       word_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rx_fire;
  logic                  last_byte;
  logic                  addr_last;
  logic                  halt_hit;
  logic                  start_ok;
  logic                  tmo_hit;

  assign rx_fire   = (state == RECV) && i_rx_valid;
  assign last_byte = rx_fire && (byte_cnt == 2'd3);
  assign addr_last = (addr_q == ADDR_WIDTH'(MAX_INSTRUCTION - 1));
  assign halt_hit  = (o_write_data == HALT_WORD);
  assign start_ok  = i_start && ((state == IDLE) || (state == DONE) || (state == ERR));

  always_ff @(posedge i_clk_write or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    o_rx_ready          = 1'b0;
    o_inst_write_enable = 1'b0;
    o_busy              = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (i_start) state_nxt = RECV;
      end
      RECV: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        if (last_byte)    state_nxt = WRITE;
        else if (tmo_hit) state_nxt = ERR;
      end
      WRITE: begin
        o_inst_write_enable = 1'b1;
        o_busy              = 1'b1;
        if (halt_hit || addr_last) state_nxt = DONE;
        else                       state_nxt = RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bytes shift in from the bottom, so after four the first byte sits in the top lane.
  always_ff @(posedge i_clk_write or posedge i_rst) begin
    if (i_rst) begin
      byte_cnt     <= 2'd0;
      word_q       <= '0;
      addr_q       <= '0;
      o_write_addr <= '0;
      o_write_data <= '0;
      o_word_count <= '0;
      o_done       <= 1'b0;
      o_truncated  <= 1'b0;
    end else begin
      if (start_ok) begin
        byte_cnt     <= 2'd0;
        addr_q       <= '0;
        o_word_count <= '0;
        o_done       <= 1'b0;
        o_truncated  <= 1'b0;
      end
      if (rx_fire) begin
        word_q   <= {word_q[SIZE-9:0], i_rx_data};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          o_write_data <= {word_q[SIZE-9:0], i_rx_data};
          o_write_addr <= addr_q;
        end
      end
      if (state == WRITE) begin
        o_word_count <= o_word_count + 1'b1;
        // Saturate at the last slot so a full memory never wraps onto word 0.
        if (!addr_last) addr_q <= addr_q + 1'b1;
        if (halt_hit) begin
          o_done <= 1'b1;
        end else if (addr_last) begin
          o_done      <= 1'b1;
          o_truncated <= 1'b1;
        end
      end
    end
  end

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  // Only a stalled partial word can time out; an idle link between words waits forever.
  assign tmo_hit = (state == RECV) && (byte_cnt != 2'd0) && !rx_fire &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign o_error = err_q;

  always_ff @(posedge i_clk_write or posedge i_rst) begin
    if (i_rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state != RECV) || rx_fire || (byte_cnt == 2'd0)) tmo_q <= '0;
      else                                                  tmo_q <= tmo_q + 1'b1;
      if (start_ok)     err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  // Keeps the timeout parameter referenced so both builds share one parameter list.
  assign o_error = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule
